uart_rx_param: RTL and testbench

// Parametrised oversampling UART receiver: configurable data width, parity, stop bits and oversample ratio.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_param_if.sv | 26 ++
 rtl/uart_rx_sampler.sv | 52 +++++
 rtl/uart_rx_param.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver control, serial input and word handshake bundle.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 en;
  logic                 tick;
  logic                 rx;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_par_err;
  logic                 out_frm_err;
  logic                 overrun;
  logic                 break_det;
  logic                 busy;

  modport master (
    output en, tick, rx, out_ready,
    input  out_data, out_valid, out_par_err, out_frm_err, overrun, break_det, busy
  );

  modport slave (
    input  en, tick, rx, out_ready,
    output out_data, out_valid, out_par_err, out_frm_err, overrun, break_det, busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// rx synchroniser, tick-qualified oversample counter and 3-sample majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic clr_i,
  input  logic rx_i,
  output logic rxs_o,
  output logic strobe_c,
  output logic wrap_c,
  output logic bitval_c
);
  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned M  = OVERSAMPLE / 2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   s0_q, s1_q;

  assign rxs_o = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      cnt_q  <= '0;
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      cnt_q  <= cnt_d;
      if (tick_i && cnt_q == CW'(M - 1)) s0_q <= rxs_o;
      if (tick_i && cnt_q == CW'(M))     s1_q <= rxs_o;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_i) cnt_d = (cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : cnt_q + CW'(1);
  end

  // Third sample is the live synchronised value at tick M+1.
  assign strobe_c = tick_i && !clr_i && (cnt_q == CW'(M + 1));
  assign wrap_c   = tick_i && !clr_i && (cnt_q == CW'(OVERSAMPLE - 1));
  assign bitval_c = maj3(s0_q, s1_q, rxs_o);

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: frame FSM, parity/framing/break checks and word holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst_n,
  uart_rx_param_if.slave bus
);
  localparam int unsigned BW = 4;

  state_e               state_q;
  logic [DATA_BITS-1:0] data_q, odata_q;
  logic [BW-1:0]        bidx_q;
  logic                 perr_q, ferr_q, pbit_q, armed_q, busy_q, dlv_q, brk_q;
  logic                 ovalid_q, opar_q, ofrm_q, ovr_q;
  logic                 rxs, strobe_c, wrap_c, bitval_c, clr_c, is_break_c;

  assign clr_c = (state_q == ST_IDLE) || (state_q == ST_BREAK) || !bus.en;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_i  (bus.tick),
    .clr_i   (clr_c),
    .rx_i    (bus.rx),
    .rxs_o   (rxs),
    .strobe_c(strobe_c),
    .wrap_c  (wrap_c),
    .bitval_c(bitval_c)
  );

  assign is_break_c = (bidx_q == BW'(0)) && (data_q == '0) &&
                      ((PARITY == PAR_NONE) || !pbit_q) && !bitval_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      bidx_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      pbit_q  <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      dlv_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      dlv_q <= 1'b0;
      brk_q <= 1'b0;
      // A start is only accepted after rxs has been seen idle while enabled.
      if (!bus.en)  armed_q <= 1'b0;
      else if (rxs) armed_q <= 1'b1;
      if (!bus.en) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (bus.tick && armed_q && !rxs) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
            bidx_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            pbit_q  <= 1'b0;
          end
          ST_START: begin
            if (strobe_c && bitval_c) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else if (wrap_c) begin
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (strobe_c) data_q <= {bitval_c, data_q[DATA_BITS-1:1]};
            if (wrap_c) begin
              if (bidx_q == BW'(DATA_BITS - 1)) begin
                bidx_q  <= '0;
                state_q <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
              end else begin
                bidx_q <= bidx_q + BW'(1);
              end
            end
          end
          ST_PARITY: begin
            if (strobe_c) begin
              pbit_q <= bitval_c;
              perr_q <= ((^data_q) ^ bitval_c) != (PARITY == PAR_ODD);
            end else if (wrap_c) begin
              state_q <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (strobe_c) begin
              if (is_break_c) begin
                state_q <= ST_BREAK;
                busy_q  <= 1'b0;
                brk_q   <= 1'b1;
              end else begin
                ferr_q <= ferr_q | ~bitval_c;
                if (bidx_q == BW'(STOP_BITS - 1)) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  dlv_q   <= 1'b1;
                end
              end
            end else if (wrap_c) begin
              bidx_q <= bidx_q + BW'(1);
            end
          end
          ST_BREAK: if (rxs) state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Holding register: a delivery into a full, unaccepted register is dropped as overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      opar_q   <= 1'b0;
      ofrm_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (dlv_q) begin
        if (!ovalid_q || bus.out_ready) begin
          odata_q  <= data_q;
          opar_q   <= perr_q;
          ofrm_q   <= ferr_q;
          ovalid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (ovalid_q && bus.out_ready) begin
        ovalid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data    = odata_q;
  assign bus.out_valid   = ovalid_q;
  assign bus.out_par_err = opar_q;
  assign bus.out_frm_err = ofrm_q;
  assign bus.overrun     = ovr_q;
  assign bus.break_det   = brk_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: an 8N1 and an 8E1 receiver share one rx line, only one enabled at a time.
module tb_uart_rx_param;
  localparam int OS = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1, tick = 1'b1, out_ready = 1'b1, en_n = 1'b0, en_e = 1'b0;
  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) if_n ();
  uart_rx_param_if #(.DATA_BITS(8)) if_e ();
  assign if_n.rx = rx;  assign if_n.tick = tick;  assign if_n.out_ready = out_ready;  assign if_n.en = en_n;
  assign if_e.rx = rx;  assign if_e.tick = tick;  assign if_e.out_ready = out_ready;  assign if_e.en = en_e;

  uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS), .SYNC_STAGES(2))
    dut_n (.clk(clk), .rst_n(rst_n), .bus(if_n));
  uart_rx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS), .SYNC_STAGES(2))
    dut_e (.clk(clk), .rst_n(rst_n), .bus(if_e));

  exp_t q_n[$], q_e[$];
  int brk_n = 0, brk_e = 0, ovr_n = 0, ovr_e = 0;
  int total = 0, bad = 0;
  int tdiv = 1, tph = 0;
  int busy_cnt_n = 0, valid_cnt_n = 0;
  bit hold_full = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    tph  = (tph + 1 >= tdiv) ? 0 : tph + 1;
    tick = (tph == 0);
  end

  // Frame-level reference: interpret the line bits as the receiver configuration sees them.
  task automatic model(input int sel, input logic [15:0] line, input bit par_en);
    logic [7:0] d;
    logic p, stop;
    exp_t e;
    if (line[0]) return;
    d    = line[8:1];
    p    = par_en ? line[9] : 1'b0;
    stop = par_en ? line[10] : line[9];
    if (d == 8'h00 && !p && !stop) begin
      if (sel == 0) brk_n++; else brk_e++;
      return;
    end
    e.data = d;
    e.perr = par_en && ((^{d, p}) == 1'b1);
    e.ferr = !stop;
    if (!out_ready && hold_full) begin
      if (sel == 0) ovr_n++; else ovr_e++;
    end else begin
      if (!out_ready) hold_full = 1;
      if (sel == 0) q_n.push_back(e); else q_e.push_back(e);
    end
  endtask

  function automatic logic [15:0] mk(input logic [7:0] d, input bit par_en, input bit pflip, input logic stop);
    logic [15:0] l;
    l = '1;
    l[0] = 1'b0;
    l[8:1] = d;
    if (par_en) begin
      l[9]  = (^d) ^ pflip;
      l[10] = stop;
    end else begin
      l[9] = stop;
    end
    return l;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int sel, input logic [15:0] line, input int glitch);
    int bt, nb;
    bt = OS * tdiv;
    nb = (sel == 1) ? 11 : 10;
    model(sel, line, sel == 1);
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < bt; c++) begin
        rx = (i == glitch && c == 9) ? ~line[i] : line[i];
        @(posedge clk);
        #1;
      end
    end
    rx = 1'b1;
    wait_clks(2 * bt);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (if_n.busy) busy_cnt_n++;
      if (if_n.out_valid) valid_cnt_n++;
      if (if_n.out_valid && if_n.out_ready) begin
        if (q_n.size() == 0) begin
          total++; bad++;
          $display("FAIL n_unexpected_word: got %0h expected none at %0t", if_n.out_data, $time);
        end else begin
          e = q_n.pop_front();
          check("n_data", if_n.out_data, e.data);
          check("n_perr", if_n.out_par_err, e.perr);
          check("n_ferr", if_n.out_frm_err, e.ferr);
        end
      end
      if (if_n.break_det) begin
        check("n_break_expected", brk_n > 0, 1);
        if (brk_n > 0) brk_n--;
      end
      if (if_n.overrun) begin
        check("n_overrun_expected", ovr_n > 0, 1);
        if (ovr_n > 0) ovr_n--;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (if_e.out_valid && if_e.out_ready) begin
        if (q_e.size() == 0) begin
          total++; bad++;
          $display("FAIL e_unexpected_word: got %0h expected none at %0t", if_e.out_data, $time);
        end else begin
          e = q_e.pop_front();
          check("e_data", if_e.out_data, e.data);
          check("e_perr", if_e.out_par_err, e.perr);
          check("e_ferr", if_e.out_frm_err, e.ferr);
        end
      end
      if (if_e.break_det) begin
        check("e_break_expected", brk_e > 0, 1);
        if (brk_e > 0) brk_e--;
      end
      if (if_e.overrun) begin
        check("e_overrun_expected", ovr_e > 0, 1);
        if (ovr_e > 0) ovr_e--;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, v0, d;
    logic [7:0] rd;
    wait_clks(5);
    check("rst_n_valid", if_n.out_valid, 0);
    check("rst_n_busy", if_n.busy, 0);
    check("rst_n_data", if_n.out_data, 0);
    check("rst_n_pulses", {if_n.break_det, if_n.overrun, if_n.out_par_err, if_n.out_frm_err}, 0);
    check("rst_e_valid", if_e.out_valid, 0);
    check("rst_e_busy", if_e.busy, 0);
    rst_n = 1'b1;
    en_n  = 1'b1;
    wait_clks(4);

    // 8N1 0xA5: one valid cycle, busy for about 9.5 bit times
    b0 = busy_cnt_n; v0 = valid_cnt_n;
    send(0, mk(8'hA5, 0, 0, 1), -1);
    wait_clks(10);
    d = busy_cnt_n - b0;
    check("busy_len_in_range", (d >= 148 && d <= 160), 1);
    check("valid_one_cycle", valid_cnt_n - v0, 1);

    // false start, then a good frame
    rx = 1'b0; wait_clks(5); rx = 1'b1; wait_clks(40);
    check("false_start_idle", if_n.busy, 0);
    send(0, mk(8'h55, 0, 0, 1), -1);

    // overrun with consumer stalled
    out_ready = 1'b0; hold_full = 0;
    send(0, mk(8'h11, 0, 0, 1), -1);
    send(0, mk(8'h22, 0, 0, 1), -1);
    check("held_valid", if_n.out_valid, 1);
    check("held_data", if_n.out_data, 8'h11);
    out_ready = 1'b1; hold_full = 0;
    wait_clks(3);
    check("valid_drop_after_accept", if_n.out_valid, 0);

    // line break, then recovery
    model(0, 16'h0000, 0);
    rx = 1'b0; wait_clks(20 * OS); rx = 1'b1; wait_clks(3 * OS);
    send(0, mk(8'h7E, 0, 0, 1), -1);

    // one-clock glitch in data bit 3
    send(0, mk(8'hFF, 0, 0, 1), 4);

    // enable drop mid-frame while rx low; re-enable must not start on a held-low line
    rx = 1'b0; wait_clks(5 * OS);
    en_n = 1'b0; wait_clks(3);
    check("abort_busy_low", if_n.busy, 0);
    wait_clks(30);
    en_n = 1'b1; wait_clks(32);
    check("no_start_without_edge", if_n.busy, 0);
    rx = 1'b1; wait_clks(3 * OS);
    send(0, mk(8'hC3, 0, 0, 1), -1);

    for (int k = 0; k < 6; k++) begin
      tdiv = $urandom_range(1, 2);
      rd = 8'($urandom);
      send(0, mk(rd, 0, 0, ($urandom_range(0, 7) != 0)), -1);
    end
    tdiv = 1;
    wait_clks(20);

    en_n = 1'b0; en_e = 1'b1;
    wait_clks(4);
    send(1, mk(8'h3C, 1, 0, 1), -1);
    send(1, mk(8'h3C, 1, 1, 1), -1);
    for (int k = 0; k < 10; k++) begin
      tdiv = $urandom_range(1, 3);
      rd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      send(1, mk(rd, 1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0)), -1);
      if (rx) wait_clks(OS * tdiv);
    end
    tdiv = 1;
    wait_clks(60);

    check("n_queue_drained", q_n.size(), 0);
    check("e_queue_drained", q_e.size(), 0);
    check("n_breaks_seen", brk_n, 0);
    check("e_breaks_seen", brk_e, 0);
    check("n_overruns_seen", ovr_n, 0);
    check("e_overruns_seen", ovr_e, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
